// File: rtl/mcp4921_pkg.sv
// rtl/mcp4921_pkg.sv - MCP4921 frame layout, error codes and responder FSM states
package mcp4921_pkg;

    localparam int BIT_AB     = 15;
    localparam int BIT_BUF    = 14;
    localparam int BIT_GA_N   = 13;
    localparam int BIT_SHDN_N = 12;
    localparam int FRAME_BITS = 16;

    localparam int          BIT_CNT_W    = 5;
    localparam logic [4:0]  BIT_CNT_FULL = 5'd16;
    localparam logic [4:0]  BIT_CNT_SAT  = 5'd17;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SHORT  = 2'b01,
        ERR_LONG   = 2'b10,
        ERR_CHAN_B = 2'b11
    } err_code_t;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        EVAL
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with registered-level edge detection
module sync_edge_detect #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/mcp4921_spi_responder.sv
// rtl/mcp4921_spi_responder.sv - oversampled MCP4921 SPI write receiver with input/output register emulation
module mcp4921_spi_responder
    import mcp4921_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_n,
    input  logic                 sclk,
    input  logic                 copi,
    input  logic                 ldac_n,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic [11:0]          in_code,
    output logic                 in_buf,
    output logic                 in_gain1x,
    output logic                 in_active,
    output logic [11:0]          dac_code,
    output logic                 dac_active,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic cs_level, cs_rise, cs_fall;
    logic sclk_rise, sclk_level_unused, sclk_fall_unused;
    logic ldac_level, ldac_fall, ldac_rise_unused;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic copi_s;

    // Select and LDAC reset to the asserted level so a pin already low at reset never looks like a fresh edge
    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
        .clk(clk), .rst(rst), .din(cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ldac_sync (
        .clk(clk), .rst(rst), .din(ldac_n),
        .level(ldac_level), .rise(ldac_rise_unused), .fall(ldac_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) copi_sync_q <= '0;
        else     copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
    end
    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic                  cs_fall_pend_q;
    logic                  ldac_fall_q;
    logic                  start, shift_en, eval;
    err_code_t             eval_err;
    logic                  eval_ok;
    logic                  dac_load;

    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        shift_en = 1'b0;
        eval     = 1'b0;
        case (state_q)
            WAIT_IDLE: if (cs_level) state_d = IDLE;
            IDLE: begin
                if (cs_fall || cs_fall_pend_q) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise)        state_d  = EVAL;
                else if (sclk_rise) shift_en = 1'b1;
            end
            EVAL: begin
                eval    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        eval_err = ERR_NONE;
        if (bit_cnt_q < BIT_CNT_FULL)      eval_err = ERR_SHORT;
        else if (bit_cnt_q > BIT_CNT_FULL) eval_err = ERR_LONG;
        else if (shreg_q[BIT_AB])          eval_err = ERR_CHAN_B;
    end
    assign eval_ok = (eval_err == ERR_NONE);

    // A pending LDAC edge that lands on a valid EVAL defers to the transparent load one cycle later
    assign dac_load = (frame_valid && !ldac_level) || (ldac_fall_q && !(eval && eval_ok));

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            cs_fall_pend_q <= 1'b0;
            ldac_fall_q    <= 1'b0;
            frame_valid    <= 1'b0;
            frame_err      <= 1'b0;
            err_code       <= ERR_NONE;
            in_code        <= '0;
            in_buf         <= 1'b0;
            in_gain1x      <= 1'b0;
            in_active      <= 1'b0;
            dac_code       <= '0;
            dac_active     <= 1'b0;
            frame_count    <= '0;
            err_count      <= '0;
        end else begin
            frame_valid    <= 1'b0;
            frame_err      <= 1'b0;
            cs_fall_pend_q <= eval && cs_fall;
            ldac_fall_q    <= ldac_fall;
            if (start) begin
                shreg_q   <= '0;
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                shreg_q <= {shreg_q[FRAME_BITS-2:0], copi_s};
                if (bit_cnt_q != BIT_CNT_SAT) bit_cnt_q <= bit_cnt_q + 5'd1;
            end
            if (eval) begin
                if (eval_ok) begin
                    frame_valid <= 1'b1;
                    in_code     <= shreg_q[11:0];
                    in_buf      <= shreg_q[BIT_BUF];
                    in_gain1x   <= shreg_q[BIT_GA_N];
                    in_active   <= shreg_q[BIT_SHDN_N];
                    if (~&frame_count) frame_count <= frame_count + CNT_ONE;
                end else begin
                    frame_err <= 1'b1;
                    err_code  <= eval_err;
                    if (~&err_count) err_count <= err_count + CNT_ONE;
                end
            end
            if (dac_load) begin
                dac_code   <= in_code;
                dac_active <= in_active;
            end
        end
    end

endmodule

// File: tb/tb_mcp4921_spi_responder.sv
// tb/tb_mcp4921_spi_responder.sv - scoreboard bench for the MCP4921 SPI responder
module tb_mcp4921_spi_responder;

    localparam int STAGES = 2;
    localparam int CW     = 2;

    logic          clk = 1'b0;
    logic          rst, cs_n, sclk, copi, ldac_n;
    logic          frame_valid, frame_err;
    logic [1:0]    err_code;
    logic [11:0]   in_code, dac_code;
    logic          in_buf, in_gain1x, in_active, dac_active;
    logic [CW-1:0] frame_count, err_count;

    mcp4921_spi_responder #(.SYNC_STAGES(STAGES), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .copi(copi), .ldac_n(ldac_n),
        .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code),
        .in_code(in_code), .in_buf(in_buf), .in_gain1x(in_gain1x), .in_active(in_active),
        .dac_code(dac_code), .dac_active(dac_active),
        .frame_count(frame_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int ev_seen = 0;

    typedef struct packed {
        logic        is_err;
        logic [1:0]  code;
        logic [11:0] in_code;
        logic        buf_b;
        logic        gain1x;
        logic        active;
        logic        dac_chk;
    } exp_t;

    exp_t        sb_q[$];
    logic        dac_pend = 1'b0;
    logic [11:0] pend_code;
    logic        pend_act;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic is_err, input logic [1:0] code, input logic [11:0] c,
                             input logic b, input logic g, input logic a, input logic d);
        exp_t e;
        e.is_err  = is_err;
        e.code    = code;
        e.in_code = c;
        e.buf_b   = b;
        e.gain1x  = g;
        e.active  = a;
        e.dac_chk = d;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (dac_pend) begin
                chk("dac_code_follow", dac_code, pend_code);
                chk("dac_active_follow", dac_active, pend_act);
                dac_pend = 1'b0;
            end
            if (frame_valid || frame_err) begin
                ev_seen++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_event", {frame_valid, frame_err}, 2'b00);
                end else begin
                    e = sb_q.pop_front();
                    chk("ev_kind", {frame_valid, frame_err}, e.is_err ? 2'b01 : 2'b10);
                    if (e.is_err) chk("err_code", err_code, e.code);
                    chk("in_code", in_code, e.in_code);
                    chk("in_buf", in_buf, e.buf_b);
                    chk("in_gain1x", in_gain1x, e.gain1x);
                    chk("in_active", in_active, e.active);
                    if (frame_valid && e.dac_chk) begin
                        dac_pend  = 1'b1;
                        pend_code = e.in_code;
                        pend_act  = e.active;
                    end
                end
            end
        end
    end

    task automatic spi_bit(input logic b);
        copi = b;
        repeat (3) @(negedge clk);
        sclk = 1'b1;
        repeat (3) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_send(input logic [31:0] word, input int nbits, input bit expect_event);
        int n;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) spi_bit(word[i]);
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        n = 0;
        while (n < 20 && !(frame_valid || frame_err)) begin
            @(negedge clk);
            n++;
        end
        if (expect_event) chk("frame_latency", n, STAGES + 2);
        repeat (6) @(negedge clk);
    endtask

    initial begin : stim
        logic [15:0] rw;
        int          seen_before;
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; copi = 1'b0; ldac_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_in_code", in_code, 0);
        chk("rst_dac_code", dac_code, 0);
        chk("rst_flags", {in_buf, in_gain1x, in_active, dac_active}, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_err_count", err_count, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        expect_ev(1'b0, 2'b00, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1); spi_send(32'h7000, 16, 1);
        expect_ev(1'b0, 2'b00, 12'h800, 1'b1, 1'b1, 1'b1, 1'b1); spi_send(32'h7800, 16, 1);
        expect_ev(1'b0, 2'b00, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b1); spi_send(32'h7FFF, 16, 1);
        chk("loop_frame_count", frame_count, 3);
        chk("loop_dac_code", dac_code, 12'hFFF);
        chk("loop_dac_active", dac_active, 1);

        expect_ev(1'b1, 2'b01, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0); spi_send(32'h1234, 15, 1);
        chk("short_err_count", err_count, 1);
        chk("short_dac_code", dac_code, 12'hFFF);
        chk("short_frame_count", frame_count, 3);

        expect_ev(1'b1, 2'b10, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0); spi_send(32'h12345, 17, 1);
        chk("long_err_count", err_count, 2);

        expect_ev(1'b1, 2'b11, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0); spi_send(32'hB123, 16, 1);
        chk("chanb_err_count", err_count, 3);
        chk("chanb_err_code_held", err_code, 2'b11);
        chk("chanb_dac_code", dac_code, 12'hFFF);

        expect_ev(1'b1, 2'b01, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0); spi_send(32'h5, 3, 1);
        chk("err_count_saturates", err_count, 3);

        ldac_n = 1'b1;
        repeat (6) @(negedge clk);
        expect_ev(1'b0, 2'b00, 12'hABC, 1'b0, 1'b1, 1'b1, 1'b0); spi_send(32'h3ABC, 16, 1);
        chk("ldac_hi_in_code", in_code, 12'hABC);
        chk("ldac_hi_dac_code", dac_code, 12'hFFF);
        chk("frame_count_saturates", frame_count, 3);
        @(negedge clk);
        ldac_n = 1'b0;
        repeat (STAGES + 1) @(negedge clk);
        chk("ldac_before_load", dac_code, 12'hFFF);
        @(negedge clk);
        chk("ldac_load_code", dac_code, 12'hABC);
        chk("ldac_load_active", dac_active, 1);
        repeat (6) @(negedge clk);

        seen_before = ev_seen;
        rw = 16'h7F0F;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 15; i >= 8; i--) spi_bit(rw[i]);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 7; i >= 0; i--) spi_bit(rw[i]);
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_event", ev_seen, seen_before);
        chk("rst_mid_frame_count", frame_count, 0);
        chk("rst_mid_err_count", err_count, 0);
        chk("rst_mid_in_code", in_code, 0);

        expect_ev(1'b0, 2'b00, 12'h555, 1'b0, 1'b0, 1'b1, 1'b1); spi_send(32'h1555, 16, 1);
        chk("post_rst_dac_active", dac_active, 1);
        chk("post_rst_in_gain1x", in_gain1x, 0);
        chk("post_rst_dac_code", dac_code, 12'h555);
        chk("post_rst_frame_count", frame_count, 1);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcp4921_spi_responder.md
# mcp4921_spi_responder

Receive-side model of the MCP4921 DAC SPI write protocol: oversamples `cs_n`/`sclk`/`copi` in the system clock domain, shifts in 16-bit MSB-first frames, decodes the control nibble and 12-bit code, and emulates the device's input and output registers with LDAC behaviour. It serves as an on-chip loopback and self-check target for the DAC SPI controller, `spi_controller_dac4091`, and as a synthesizable bench model, driving the decoded DAC state and error counters to debug LEDs and ILA probes.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of input synchronizers (≥2).
- `CNT_WIDTH`, 16: width of frame/error counters.
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: synchronous, active-high reset.
- `cs_n` in 1: SPI chip select, active low, async to `clk`.
- `sclk` in 1: SPI clock, mode 0,0; data sampled on rising edge.
- `copi` in 1: SPI data, MSB first.
- `ldac_n` in 1: latch-DAC input, active low.
- `frame_valid` out 1: one-cycle pulse, well-formed frame accepted.
- `frame_err` out 1: one-cycle pulse, malformed or ignored frame.
- `err_code` out 2: cause, valid with `frame_err`; held until next error.
- `in_code` out 12: input register code.
- `in_buf`, `in_gain1x`, `in_active` out 1 each: input register control bits.
- `dac_code` out 12: output register code (the emulated VOUT code).
- `dac_active` out 1: output register SHDN_n; 0 = shutdown.
- `frame_count` out CNT_WIDTH: accepted frames, saturating.
- `err_count` out CNT_WIDTH: error frames, saturating.

## Operation
- Frame format: bit15 A/B (must be 0), bit14 BUF, bit13 GA_n (1 = 1x), bit12 SHDN_n, bits 11:0 code.
- Synchronize `cs_n`, `sclk`, `ldac_n`, `copi` through SYNC_STAGES flops. Edge detection runs on the synchronized `cs_n`, `sclk`, and `ldac_n`.
- FSM states:
  - **WAIT_IDLE**: entered from reset. Moves to IDLE once synced `cs_n` = 1. A select already active at reset release is never captured.
  - **IDLE**: synced `cs_n` falling edge → SHIFT. Clears the shift register and the 5-bit bit counter.
  - **SHIFT**: each synced `sclk` rising edge shifts in synced `copi`. The bit counter saturates at 17. Synced `cs_n` rising edge → EVAL.
  - **EVAL**: single cycle, then returns to IDLE.
- EVAL classification:
  - count < 16: `frame_err`, `err_code` = 01 (SHORT).
  - count > 16: `frame_err`, `err_code` = 10 (LONG).
  - count = 16 and bit15 = 1: `frame_err`, `err_code` = 11 (CHAN_B). Registers are unchanged, as the MCP4921 ignores the write.
  - Otherwise: `frame_valid`, load the input register, and increment `frame_count`.
  - Any error increments `err_count`.
- Output register loads from the input register:
  - On a valid EVAL, when synced `ldac_n` = 0. This is the transparent mode, since the controller ties LDAC low.
  - On any synced `ldac_n` falling edge. This reloads the current input register even if it is unchanged.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset values:
  - FSM = WAIT_IDLE.
  - `frame_valid`, `frame_err` = 0; `err_code` = 00.
  - `in_code`, `dac_code` = 0.
  - `in_buf`, `in_gain1x`, `in_active`, `dac_active` = 0.
  - Both counters = 0.
- Latency:
  - `cs_n` rise at pin → `frame_valid`/`frame_err`: SYNC_STAGES + 2 cycles.
  - `in_*` update in the same cycle as `frame_valid`.
  - `dac_*` update 1 cycle after `frame_valid` in transparent mode.
  - `ldac_n` falling edge at pin → `dac_*` update: SYNC_STAGES + 2 cycles.
- Input constraint: each `sclk` high and low phase ≥ 2 `clk` cycles, i.e. controller SCLK_DIV ≥ 4. Faster clocks give undefined bit counts.
- Simultaneous events:
  - A synced `sclk` rise in the same cycle as a synced `cs_n` rise is ignored (not shifted).
  - A valid EVAL coinciding with an `ldac_n` falling edge performs a single load with the new frame.
- `rst` mid-frame discards the partial frame and returns to WAIT_IDLE. No `frame_err` is produced.
- A `cs_n` falling edge during EVAL is caught one cycle later in IDLE, because the edge flag is held until consumed.

## Structure
- Package `mcp4921_pkg` holds:
  - Bit-position localparams (`BIT_AB` = 15, `BIT_BUF` = 14, `BIT_GA_N` = 13, `BIT_SHDN_N` = 12).
  - `FRAME_BITS` = 16.
  - `err_code_t` enum (`ERR_NONE`, `ERR_SHORT`, `ERR_LONG`, `ERR_CHAN_B`).
  - FSM `state_t` enum.
- Sub-module `sync_edge_detect` (parameter `STAGES`; outputs `level`, `rise`, `fall`) is instantiated for `cs_n`, `sclk`, `ldac_n`. `copi` uses a plain synchronizer of equal depth so alignment is preserved.

## Test plan
- **Transparent loopback**: `spi_controller_dac4091` (SCLK_DIV = 6, BUF = 1, GAIN1X = 1, ACTIVE = 1) sends codes 0x000, 0x800, 0xFFF with `ldac_n` = 0.
  - Each produces `frame_valid`; `dac_code` follows; `dac_active` = 1; `frame_count` = 3.
- **Short frame**: raise `cs_n` after 15 clocks.
  - `frame_err` with `err_code` = 01; registers unchanged; `err_count` = 1.
- **Long frame**: 17 clocks.
  - `err_code` = 10.
- **Channel B frame**: 0xB123.
  - `err_code` = 11; `in_code` keeps its prior value.
- **LDAC held high**: send 0x3ABC.
  - `in_code` = 0xABC, `dac_code` unchanged.
  - Pulse `ldac_n` low: `dac_code` = 0xABC exactly SYNC_STAGES + 2 cycles later.
- **Reset robustness**:
  - Assert `rst` after 8 bits; release with `cs_n` still low, then finish the clocks: no `frame_valid`/`frame_err`.
  - Next full frame 0x1555 is accepted: `dac_active` = 1, `in_gain1x` = 0, `dac_code` = 0x555.
